tt_core_harness: RTL and testbench
==================================

Name: tt_core_harness

Overview:
Parametrised successor to the single-project top-level wrapper. It sits between the TinyTapeout pin interface and NUM_CORES user cores. It selects one core at reset release, stretches that core's reset, and then does one of two things:
- passes pins through transparently (RUN), or
- runs an on-chip self-test, driving the core from an LFSR and compressing its outputs into a MISR signature that is read back on uo_out.

Parameters:
NUM_CORES, 4, number of attached cores (2..16); SEL_W = max(1, clog2(NUM_CORES)) derived localparam.
SIG_CYCLES, 256, cycles of LFSR stimulus in signature mode (1..65535).
RST_STRETCH, 2, cycles core_rst_n is held low after selection (1..15).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; low freezes harness state
ui_in  in  8  dedicated inputs; at reset release: [SEL_W-1:0] core select, [7] mode (0 RUN, 1 SIG); in DONE: [0] byte select
uo_out  out  8  dedicated outputs
uio_in  in  8  bidir input path
uio_out  out  8  bidir output path
uio_oe  out  8  bidir enable, 1 = output
core_ui  out  8*NUM_CORES  per-core ui_in, core i at [8i+7:8i]
core_uio_in  out  8*NUM_CORES  per-core uio_in
core_uo  in  8*NUM_CORES  per-core uo_out
core_uio_out  in  8*NUM_CORES  per-core uio_out
core_uio_oe  in  8*NUM_CORES  per-core uio_oe
core_rst_n  out  NUM_CORES  per-core active-low reset, registered
core_ena  out  NUM_CORES  per-core enable

Behaviour:
- Reset (rst_n low, async):
  - state=SAMPLE; all core_rst_n=0, core_ena=0.
  - uo_out=0, uio_out=0, uio_oe=0.
  - LFSR=8'h01, MISR=16'h0000, counter=0.
- ena low: state, counter, LFSR and MISR hold; core_ena all 0; outputs keep their current mapping.
- Core select and enable: non-selected cores keep core_rst_n=0, core_ui=0, core_uio_in=0 at all times. core_ena[sel]=ena only in CORE_RST/RUN/SIG.
- SAMPLE: on the first enabled clk edge, latch sel=ui_in[SEL_W-1:0] and mode=ui_in[7].
  - sel>=NUM_CORES -> ERROR.
  - otherwise -> CORE_RST, counter=0.
- CORE_RST: core_rst_n[sel]=0 for RST_STRETCH cycles, then registered to 1. Next state is RUN (mode 0) or SIG (mode 1).
- RUN: purely combinational pass-through of the selected core.
  - core_ui[sel]=ui_in, core_uio_in[sel]=uio_in.
  - uo_out, uio_out, uio_oe = selected core's outputs.
  - No further transitions until reset.
- SIG: each enabled cycle:
  - core_ui[sel]=LFSR, core_uio_in[sel]=~LFSR.
  - LFSR is a Galois 8-bit LFSR with poly x^8+x^6+x^5+x^4+1; it shifts once per cycle.
  - MISR update, using the CRC-CCITT poly 0x1021: next = {m[14:0],0} ^ (m[15] ? 16'h1021 : 0) ^ {8'h00, core_uo[sel]}.
  - uo_out=0, uio_oe=0.
  - counter increments. After SIG_CYCLES updates -> DONE; the MISR is frozen.
  - The core's outputs are sampled in the same cycle the stimulus is applied (combinational core path is captured).
- DONE:
  - uo_out = ui_in[0] ? MISR[15:8] : MISR[7:0] (combinational on ui_in[0]).
  - uio_out=8'hA5, uio_oe=8'hFF.
  - Selected core stays enabled with its stimulus held at the last LFSR value.
- ERROR: uo_out=8'hEE, uio_out=0, uio_oe=0; every core held in reset.
- Reset asserted in any state returns to SAMPLE immediately, with every register at its reset value. Mid-signature progress is discarded.
- Only rst_n exits DONE, ERROR and RUN.

Optional Feature:
- Macro: HARNESS_MISR_UIO_EN.
- Defined: the MISR update additionally XORs {core_uio_out[sel] & core_uio_oe[sel], 8'h00}.
- Undefined: only uo_out is compressed, and core_uio_out/core_uio_oe are ignored in SIG.
- RUN behaviour is identical in both cases.

Decomposition:
- Package tt_harness_pkg holds:
  - the state enum (SAMPLE, CORE_RST, RUN, SIG, DONE, ERROR);
  - LFSR_POLY=8'hB8 equivalent taps and LFSR_SEED=8'h01;
  - MISR_POLY=16'h1021 and MISR_SEED=16'h0000;
  - DONE_MARK=8'hA5 and ERR_MARK=8'hEE.
- Sub-module tt_harness_misr: 16-bit MISR with enable, clear and two 8-bit data inputs.

Test Plan:
- Reset with ui_in=8'h02, NUM_CORES=4; release -> core_rst_n=4'b0000 for 1+RST_STRETCH cycles, then 4'b0100. ui_in=8'h3C must appear on core_ui[23:16]. Core 2 uo=8'h5A must appear on uo_out.
- Reset with ui_in=8'h07, NUM_CORES=4 (sel 3 valid) vs NUM_CORES=3 (sel 3 invalid) -> RUN on core 3 vs ERROR with uo_out=8'hEE and all core_rst_n=0.
- SIG mode (ui_in=8'h80) with a stub core driving uo=0, SIG_CYCLES=256 -> after 256 cycles uio_out=8'hA5, uio_oe=8'hFF, uo_out=8'h00 for both ui_in[0] values.
- SIG mode with a stub core echoing core_ui to uo -> uo_out low/high bytes match the bench LFSR+MISR model. First stimulus 8'h01, second 8'hB8.
- Drop ena for 10 cycles mid-SIG -> counter, LFSR and MISR unchanged. The final signature equals the uninterrupted run.
- Assert rst_n at SIG cycle 100 -> outputs 0 asynchronously. Re-release with ui_in=8'h01 -> RUN on core 1 with no residual MISR state.

Source files
------------

// File: rtl/tt_harness_pkg.sv
// Shared types and constants for the TinyTapeout multi-core harness.
// Holds the state encoding, LFSR/MISR polynomials and seeds, and the marker bytes shown on the pins.
package tt_harness_pkg;

    typedef enum logic [2:0] {
        SAMPLE   = 3'd0,
        CORE_RST = 3'd1,
        RUN      = 3'd2,
        SIG      = 3'd3,
        DONE     = 3'd4,
        ERROR    = 3'd5
    } state_t;

    localparam logic [7:0]  LFSR_POLY = 8'hB8;
    localparam logic [7:0]  LFSR_SEED = 8'h01;
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'h0000;
    localparam logic [7:0]  DONE_MARK = 8'hA5;
    localparam logic [7:0]  ERR_MARK  = 8'hEE;

    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/tt_harness_misr.sv
// 16-bit CRC-CCITT style MISR: one update per cycle while en is high, clr reloads the seed (clr wins).
// Latency: signature reflects the data one cycle after it is presented; no backpressure.
module tt_harness_misr
    import tt_harness_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic [7:0]  d_lo,
    input  logic [7:0]  d_hi,
    output logic [15:0] sig
);

    logic [15:0] misr_q;
    logic [15:0] misr_d;

    always_comb begin
        misr_d = misr_q;
        if (clr) begin
            misr_d = MISR_SEED;
        end else if (en) begin
            misr_d = {misr_q[14:0], 1'b0}
                   ^ (misr_q[15] ? MISR_POLY : 16'h0000)
                   ^ {d_hi, d_lo};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misr_q <= MISR_SEED;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign sig = misr_q;

endmodule

// File: rtl/tt_core_harness.sv
// Selects one of NUM_CORES cores at reset release, stretches its reset, then runs pass-through or LFSR/MISR self-test (HARNESS_MISR_UIO_EN also folds core uio into the MISR).
// Latency: RUN is combinational, core reset releases 1+RST_STRETCH cycles after rst_n; no backpressure, ena low freezes all state.
module tt_core_harness
    import tt_harness_pkg::*;
#(
    parameter int NUM_CORES   = 4,
    parameter int SIG_CYCLES  = 256,
    parameter int RST_STRETCH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [7:0]               ui_in,
    output logic [7:0]               uo_out,
    input  logic [7:0]               uio_in,
    output logic [7:0]               uio_out,
    output logic [7:0]               uio_oe,
    output logic [8*NUM_CORES-1:0]   core_ui,
    output logic [8*NUM_CORES-1:0]   core_uio_in,
    input  logic [8*NUM_CORES-1:0]   core_uo,
    input  logic [8*NUM_CORES-1:0]   core_uio_out,
    input  logic [8*NUM_CORES-1:0]   core_uio_oe,
    output logic [NUM_CORES-1:0]     core_rst_n,
    output logic [NUM_CORES-1:0]     core_ena
);

    localparam int SEL_W = (NUM_CORES <= 2) ? 1 : $clog2(NUM_CORES);
    localparam int CNT_W = 16;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [NUM_CORES-1:0] core_rst_n_q, core_rst_n_d;

    logic [7:0]  sel_uo;
    logic [7:0]  sel_uio_out;
    logic [7:0]  sel_uio_oe;
    logic [7:0]  misr_hi;
    logic [15:0] misr_sig;
    logic        misr_en;
    logic        misr_clr;

    always_comb begin
        sel_uo      = 8'h00;
        sel_uio_out = 8'h00;
        sel_uio_oe  = 8'h00;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_uo      = core_uo[8*i +: 8];
                sel_uio_out = core_uio_out[8*i +: 8];
                sel_uio_oe  = core_uio_oe[8*i +: 8];
            end
        end
    end

    // Next-state logic; every register holds while ena is low.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        if (ena) begin
            case (state_q)
                SAMPLE: begin
                    sel_d  = ui_in[SEL_W-1:0];
                    mode_d = ui_in[7];
                    cnt_d  = '0;
                    if (int'(ui_in[SEL_W-1:0]) >= NUM_CORES) begin
                        state_d = ERROR;
                    end else begin
                        state_d = CORE_RST;
                    end
                end
                CORE_RST: begin
                    if (cnt_q == CNT_W'(RST_STRETCH - 1)) begin
                        cnt_d   = '0;
                        state_d = mode_q ? SIG : RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SIG: begin
                    cnt_d = cnt_q + 1'b1;
                    // The final stimulus stays on the core once the signature is frozen.
                    if (cnt_q == CNT_W'(SIG_CYCLES - 1)) begin
                        state_d = DONE;
                    end else begin
                        lfsr_d = lfsr_next(lfsr_q);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        core_rst_n_d = core_rst_n_q;
        if (ena) begin
            core_rst_n_d = '0;
            if (state_d == RUN || state_d == SIG || state_d == DONE) begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    core_rst_n_d[i] = (sel_d == SEL_W'(i));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SAMPLE;
            sel_q        <= '0;
            mode_q       <= 1'b0;
            cnt_q        <= '0;
            lfsr_q       <= LFSR_SEED;
            core_rst_n_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
            lfsr_q       <= lfsr_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign core_rst_n = core_rst_n_q;

`ifdef HARNESS_MISR_UIO_EN
    assign misr_hi = sel_uio_out & sel_uio_oe;
`else
    assign misr_hi = 8'h00;
`endif

    assign misr_en  = ena && (state_q == SIG);
    assign misr_clr = ena && (state_q == SAMPLE);

    tt_harness_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (misr_en),
        .clr   (misr_clr),
        .d_lo  (sel_uo),
        .d_hi  (misr_hi),
        .sig   (misr_sig)
    );

    // Pin and per-core drive; unselected cores always see zeros.
    always_comb begin
        uo_out      = 8'h00;
        uio_out     = 8'h00;
        uio_oe      = 8'h00;
        core_ui     = '0;
        core_uio_in = '0;
        core_ena    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                case (state_q)
                    CORE_RST: begin
                        core_ena[i] = ena;
                    end
                    RUN: begin
                        core_ena[i]           = ena;
                        core_ui[8*i +: 8]     = ui_in;
                        core_uio_in[8*i +: 8] = uio_in;
                    end
                    SIG, DONE: begin
                        core_ena[i]           = ena;
                        core_ui[8*i +: 8]     = lfsr_q;
                        core_uio_in[8*i +: 8] = ~lfsr_q;
                    end
                    default: begin
                    end
                endcase
            end
        end
        case (state_q)
            RUN: begin
                uo_out  = sel_uo;
                uio_out = sel_uio_out;
                uio_oe  = sel_uio_oe;
            end
            DONE: begin
                uo_out  = ui_in[0] ? misr_sig[15:8] : misr_sig[7:0];
                uio_out = DONE_MARK;
                uio_oe  = 8'hFF;
            end
            ERROR: begin
                uo_out = ERR_MARK;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_tt_core_harness.sv
// Randomised self-checking bench for tt_core_harness: a 4-core and a 3-core instance share pins,
// stub cores are modelled here, and signatures come from a CRC/LFSR reference computed from scratch.
module tb_tt_core_harness;

    localparam int NC   = 4;
    localparam int NC3  = 3;
    localparam int SIGC = 256;
    localparam int RSTS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ena;
    logic [7:0]  ui_in;
    logic [7:0]  uio_in;
    logic [7:0]  uo_out, uio_out, uio_oe;
    logic [31:0] core_ui, core_uio_in, core_uo, core_uio_out, core_uio_oe;
    logic [3:0]  core_rst_n, core_ena;

    logic [7:0]  uo3, uio_out3, uio_oe3;
    logic [23:0] core_ui3, core_uio_in3, core_uo3, core_uio_out3, core_uio_oe3;
    logic [2:0]  core_rst_n3, core_ena3;

    int          stub_mode;
    logic [7:0]  run_uo  [4];
    logic [7:0]  run_uio [4];
    logic [7:0]  run_oe  [4];

    int checks = 0;
    int errors = 0;

    tt_core_harness #(.NUM_CORES(NC), .SIG_CYCLES(SIGC), .RST_STRETCH(RSTS)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe),
        .core_ui(core_ui), .core_uio_in(core_uio_in), .core_uo(core_uo),
        .core_uio_out(core_uio_out), .core_uio_oe(core_uio_oe),
        .core_rst_n(core_rst_n), .core_ena(core_ena)
    );

    tt_core_harness #(.NUM_CORES(NC3), .SIG_CYCLES(SIGC), .RST_STRETCH(RSTS)) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo3),
        .uio_in(uio_in), .uio_out(uio_out3), .uio_oe(uio_oe3),
        .core_ui(core_ui3), .core_uio_in(core_uio_in3), .core_uo(core_uo3),
        .core_uio_out(core_uio_out3), .core_uio_oe(core_uio_oe3),
        .core_rst_n(core_rst_n3), .core_ena(core_ena3)
    );

    // Stub cores: 0 = silent, 1 = echo stimulus, 2 = fixed per-core pattern.
    always_comb begin
        core_uo = '0; core_uio_out = '0; core_uio_oe = '0;
        core_uo3 = '0; core_uio_out3 = '0; core_uio_oe3 = '0;
        for (int i = 0; i < 4; i++) begin
            if (stub_mode == 1) begin
                core_uo[8*i +: 8]      = core_ui[8*i +: 8];
                core_uio_out[8*i +: 8] = core_uio_in[8*i +: 8];
                core_uio_oe[8*i +: 8]  = 8'h0F;
            end else if (stub_mode == 2) begin
                core_uo[8*i +: 8]      = run_uo[i];
                core_uio_out[8*i +: 8] = run_uio[i];
                core_uio_oe[8*i +: 8]  = run_oe[i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (stub_mode == 1) begin
                core_uo3[8*i +: 8]      = core_ui3[8*i +: 8];
                core_uio_out3[8*i +: 8] = core_uio_in3[8*i +: 8];
                core_uio_oe3[8*i +: 8]  = 8'h0F;
            end else if (stub_mode == 2) begin
                core_uo3[8*i +: 8]      = run_uo[i];
                core_uio_out3[8*i +: 8] = run_uio[i];
                core_uio_oe3[8*i +: 8]  = run_oe[i];
            end
        end
    end

    // Reference: stimulus is the k-th state of the Galois LFSR from seed 1.
    function automatic logic [7:0] model_stim(input int k);
        logic [7:0] s;
        s = 8'h01;
        for (int j = 0; j < k; j++) begin
            s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
        end
        return s;
    endfunction

    // Reference signature of an echo core after n cycles, as polynomial division modulo 0x11021.
    function automatic logic [15:0] model_sig(input int n);
        logic [15:0] m;
        logic [16:0] t;
        logic [7:0]  s;
        logic [7:0]  hi;
        m = 16'h0000;
        for (int k = 0; k < n; k++) begin
            s = model_stim(k);
`ifdef HARNESS_MISR_UIO_EN
            hi = ~s & 8'h0F;
`else
            hi = 8'h00;
`endif
            t = {m, 1'b0};
            if (t[16]) t = t ^ 17'h11021;
            m = t[15:0] ^ {hi, s};
        end
        return m;
    endfunction

    task automatic do_reset(input logic [7:0] ui);
        @(negedge clk);
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = ui;
        uio_in = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (uio_out !== 8'hA5 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic read_sig(output logic [15:0] sig);
        ui_in = 8'h00; #1;
        sig[7:0] = uo_out;
        ui_in = 8'h01; #1;
        sig[15:8] = uo_out;
    endtask

    task automatic test_reset();
        stub_mode = 2;
        for (int i = 0; i < 4; i++) begin
            run_uo[i] = 8'h80 | 8'($urandom_range(1, 127));
            run_uio[i] = 8'($urandom); run_oe[i] = 8'hFF;
        end
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'($urandom); uio_in = 8'($urandom);
        repeat (3) @(negedge clk);
        checks++; if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++; $display("FAIL reset_pins: got uo=%h uio=%h oe=%h expected 00 00 00", uo_out, uio_out, uio_oe);
        end
        checks++; if (core_rst_n !== 4'b0000 || core_ena !== 4'b0000) begin
            errors++; $display("FAIL reset_core: got rst_n=%b ena=%b expected 0000 0000", core_rst_n, core_ena);
        end
        checks++; if (core_ui !== 32'h0 || core_uio_in !== 32'h0) begin
            errors++; $display("FAIL reset_core_in: got ui=%h uio=%h expected 0", core_ui, core_uio_in);
        end
    endtask

    task automatic test_run_select();
        logic [7:0] u, v;
        stub_mode = 2;
        run_uo[2] = 8'h5A;
        do_reset(8'h02);
        checks++; if (core_rst_n !== 4'b0000) begin
            errors++; $display("FAIL rst_stretch_0: got %b expected 0000", core_rst_n);
        end
        for (int k = 0; k < RSTS; k++) begin
            @(negedge clk);
            checks++; if (core_rst_n !== 4'b0000) begin
                errors++; $display("FAIL rst_stretch_%0d: got %b expected 0000", k + 1, core_rst_n);
            end
        end
        @(negedge clk);
        checks++; if (core_rst_n !== 4'b0100 || core_ena !== 4'b0100) begin
            errors++; $display("FAIL rst_release: got rst_n=%b ena=%b expected 0100 0100", core_rst_n, core_ena);
        end
        ui_in = 8'h3C; #1;
        checks++; if (core_ui[23:16] !== 8'h3C || uo_out !== 8'h5A) begin
            errors++; $display("FAIL run_basic: got core_ui=%h uo=%h expected 3c 5a", core_ui[23:16], uo_out);
        end
        for (int k = 0; k < 8; k++) begin
            u = 8'($urandom); v = 8'($urandom);
            run_uo[2] = 8'($urandom); run_uio[2] = 8'($urandom); run_oe[2] = 8'($urandom);
            ui_in = u; uio_in = v;
            @(negedge clk);
            checks++; if (core_ui !== {8'h00, u, 16'h0000} || core_uio_in !== {8'h00, v, 16'h0000}) begin
                errors++; $display("FAIL run_drive: got ui=%h uio=%h expected %h %h", core_ui, core_uio_in,
                                   {8'h00, u, 16'h0000}, {8'h00, v, 16'h0000});
            end
            checks++; if (uo_out !== run_uo[2] || uio_out !== run_uio[2] || uio_oe !== run_oe[2]) begin
                errors++; $display("FAIL run_return: got %h %h %h expected %h %h %h", uo_out, uio_out, uio_oe,
                                   run_uo[2], run_uio[2], run_oe[2]);
            end
        end
        ena = 1'b0; #1;
        checks++; if (core_ena !== 4'b0000 || uo_out !== run_uo[2] || core_rst_n !== 4'b0100) begin
            errors++; $display("FAIL run_ena_low: got ena=%b uo=%h rst_n=%b expected 0000 %h 0100",
                               core_ena, uo_out, core_rst_n, run_uo[2]);
        end
        ena = 1'b1;
    endtask

    task automatic test_select_error();
        stub_mode = 2;
        do_reset(8'h07);
        repeat (RSTS + 1) @(negedge clk);
        checks++; if (core_rst_n !== 4'b1000 || uo_out !== run_uo[3] || uio_oe !== run_oe[3]) begin
            errors++; $display("FAIL sel3_run: got rst_n=%b uo=%h oe=%h expected 1000 %h %h",
                               core_rst_n, uo_out, uio_oe, run_uo[3], run_oe[3]);
        end
        for (int k = 0; k < 3; k++) begin
            ui_in = 8'($urandom);
            @(negedge clk);
            checks++; if (uo3 !== 8'hEE || uio_out3 !== 8'h00 || uio_oe3 !== 8'h00) begin
                errors++; $display("FAIL sel3_error_pins: got %h %h %h expected ee 00 00", uo3, uio_out3, uio_oe3);
            end
            checks++; if (core_rst_n3 !== 3'b000 || core_ena3 !== 3'b000 || core_ui3 !== 24'h0) begin
                errors++; $display("FAIL sel3_error_core: got rst_n=%b ena=%b ui=%h expected 000 000 0",
                                   core_rst_n3, core_ena3, core_ui3);
            end
        end
    endtask

    task automatic test_sig_zero();
        int cyc;
        logic [15:0] sig;
        stub_mode = 0;
        do_reset(8'h80);
        repeat (RSTS + 1) @(negedge clk);
        checks++; if (uo_out !== 8'h00 || uio_oe !== 8'h00 || core_ena !== 4'b0001) begin
            errors++; $display("FAIL sig_zero_active: got uo=%h oe=%h ena=%b expected 00 00 0001", uo_out, uio_oe, core_ena);
        end
        wait_done(SIGC + 50, cyc);
        checks++; if (cyc !== SIGC) begin
            errors++; $display("FAIL sig_zero_len: got %0d cycles expected %0d", cyc, SIGC);
        end
        repeat (3) @(negedge clk);
        read_sig(sig);
        checks++; if (sig !== 16'h0000 || uio_out !== 8'hA5 || uio_oe !== 8'hFF) begin
            errors++; $display("FAIL sig_zero_done: got sig=%h uio=%h oe=%h expected 0000 a5 ff", sig, uio_out, uio_oe);
        end
    endtask

    task automatic test_sig_echo();
        int cyc;
        logic [15:0] sig, exp_sig;
        stub_mode = 1;
        do_reset(8'h80);
        repeat (RSTS + 1) @(negedge clk);
        checks++; if (core_ui[7:0] !== 8'h01 || core_uio_in[7:0] !== 8'hFE) begin
            errors++; $display("FAIL echo_first: got %h %h expected 01 fe", core_ui[7:0], core_uio_in[7:0]);
        end
        @(negedge clk);
        checks++; if (core_ui[7:0] !== 8'hB8) begin
            errors++; $display("FAIL echo_second: got %h expected b8", core_ui[7:0]);
        end
        for (int k = 2; k < 12; k++) begin
            @(negedge clk);
            checks++; if (core_ui[7:0] !== model_stim(k)) begin
                errors++; $display("FAIL echo_stim_%0d: got %h expected %h", k, core_ui[7:0], model_stim(k));
            end
        end
        wait_done(SIGC, cyc);
        checks++; if (cyc !== SIGC - 11) begin
            errors++; $display("FAIL echo_len: got %0d cycles expected %0d", cyc, SIGC - 11);
        end
        exp_sig = model_sig(SIGC);
        read_sig(sig);
        checks++; if (sig !== exp_sig) begin
            errors++; $display("FAIL echo_sig: got %h expected %h", sig, exp_sig);
        end
        checks++; if (core_ui[7:0] !== model_stim(SIGC - 1) || core_ena !== 4'b0001 || core_rst_n !== 4'b0001) begin
            errors++; $display("FAIL echo_done_hold: got ui=%h ena=%b rst_n=%b expected %h 0001 0001",
                               core_ui[7:0], core_ena, core_rst_n, model_stim(SIGC - 1));
        end
    endtask

    task automatic test_ena_pause();
        int cyc;
        logic [15:0] sig, exp_sig;
        stub_mode = 1;
        do_reset(8'h80);
        repeat (RSTS + 1) @(negedge clk);
        repeat (50) @(negedge clk);
        ena = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (core_ui[7:0] !== model_stim(50) || core_ena !== 4'b0000 || uio_oe !== 8'h00) begin
            errors++; $display("FAIL pause_hold: got ui=%h ena=%b oe=%h expected %h 0000 00",
                               core_ui[7:0], core_ena, uio_oe, model_stim(50));
        end
        ena = 1'b1;
        wait_done(SIGC + 50, cyc);
        checks++; if (cyc !== SIGC - 50) begin
            errors++; $display("FAIL pause_len: got %0d cycles expected %0d", cyc, SIGC - 50);
        end
        exp_sig = model_sig(SIGC);
        read_sig(sig);
        checks++; if (sig !== exp_sig) begin
            errors++; $display("FAIL pause_sig: got %h expected %h", sig, exp_sig);
        end
    endtask

    task automatic test_reset_mid_sig();
        int cyc;
        logic [15:0] sig, exp_sig;
        stub_mode = 1;
        do_reset(8'h80);
        repeat (RSTS + 1) @(negedge clk);
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (core_rst_n !== 4'b0000 || core_ena !== 4'b0000 || core_ui !== 32'h0 || uo_out !== 8'h00) begin
            errors++; $display("FAIL midsig_async: got rst_n=%b ena=%b ui=%h uo=%h expected 0000 0000 0 00",
                               core_rst_n, core_ena, core_ui, uo_out);
        end
        stub_mode = 2;
        do_reset(8'h01);
        repeat (RSTS + 1) @(negedge clk);
        checks++; if (core_rst_n !== 4'b0010 || uo_out !== run_uo[1] || uio_out !== run_uio[1]) begin
            errors++; $display("FAIL midsig_run1: got rst_n=%b uo=%h uio=%h expected 0010 %h %h",
                               core_rst_n, uo_out, uio_out, run_uo[1], run_uio[1]);
        end
        stub_mode = 1;
        do_reset(8'h81);
        repeat (RSTS + 1) @(negedge clk);
        checks++; if (core_ui[15:8] !== 8'h01 || core_ui[7:0] !== 8'h00) begin
            errors++; $display("FAIL midsig_core1_stim: got %h expected 0100", core_ui[15:0]);
        end
        wait_done(SIGC + 50, cyc);
        exp_sig = model_sig(SIGC);
        read_sig(sig);
        checks++; if (cyc !== SIGC || sig !== exp_sig) begin
            errors++; $display("FAIL midsig_fresh_sig: got %0d cycles sig=%h expected %0d %h", cyc, sig, SIGC, exp_sig);
        end
    endtask

    initial begin
        stub_mode = 0;
        rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
        test_reset();
        test_run_select();
        test_select_error();
        test_sig_zero();
        test_sig_echo();
        test_ena_pause();
        test_reset_mid_sig();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
